// File: rtl/vga_bitmap_capture.sv
// VGA receive side: locks to hsync/vsync, samples each 8x8 cell centre of the 64x64 window, emits one 64-bit bitmap per frame.
// One dclk of input registration, no backpressure; define VGA_CAP_ERRCNT_EN to add the sync_err lock-loss counter.
module vga_bitmap_capture #(
  parameter int HPIXELS  = 800,
  parameter int VLINES   = 525,
  parameter int HPULSE   = 96,
  parameter int HBP      = 48,
  parameter int VPULSE   = 2,
  parameter int VBP      = 33,
  parameter int PAD_LEFT = 288,
  parameter int PAD_TOP  = 208,
  parameter int THRESH   = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        locked,
  output logic [63:0] frame_data,
  output logic        frame_valid
`ifdef VGA_CAP_ERRCNT_EN
  ,
  output logic [7:0]  sync_err
`endif
);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_WAIT_V  = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  localparam logic [9:0] HLAST    = 10'(HPIXELS - 1);
  localparam logic [9:0] VLAST    = 10'(VLINES - 1);
  localparam logic [9:0] H_ACT    = 10'(HPULSE + HBP);
  localparam logic [9:0] V_ACT    = 10'(VPULSE + VBP);
  localparam logic [9:0] X0       = 10'(PAD_LEFT);
  localparam logic [9:0] Y0       = 10'(PAD_TOP);
  localparam logic [3:0] THRESH_V = 4'(THRESH);
  localparam logic [7:0] GOOD_MAX = 8'(LOCK_CNT - 1);

  logic       hs_r, vs_r, hs_d, vs_d;
  logic [3:0] red_r;
  logic       hs_fall, vs_fall;

  logic [9:0] hc, vc;
  logic [1:0] state, state_nx;
  logic [7:0] goodcnt, goodcnt_nx;

  logic [63:0] shadow, seen;
  logic        line_good, lose_lock, capture, sample;
  logic [9:0]  ax, ay, wx, wy;
  logic        in_win;
  logic [5:0]  idx;

  // green/blue carry no bitmap information
  logic unused_video;
  assign unused_video = ^{green, blue};

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      red_r <= 4'd0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
      red_r <= red;
    end
  end

  assign hs_fall = hs_d & ~hs_r;
  assign vs_fall = vs_d & ~vs_r;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else begin
      if (hs_fall)
        hc <= 10'd0;
      else if (hc != 10'h3FF)
        hc <= hc + 10'd1;
      // vsync wins when both syncs fall together
      if (vs_fall)
        vc <= 10'd0;
      else if (hs_fall)
        vc <= vc + 10'd1;
    end
  end

  assign line_good = (hc == HLAST);
  assign lose_lock = (state == S_LOCKED) &&
                     ((hs_fall && !line_good) || (vs_fall && (vc != VLAST)));

  always_comb begin
    state_nx   = state;
    goodcnt_nx = goodcnt;
    case (state)
      S_SEARCH: begin
        if (hs_fall) begin
          state_nx   = S_MEASURE;
          goodcnt_nx = 8'd0;
        end
      end
      S_MEASURE: begin
        if (hs_fall) begin
          if (!line_good)
            state_nx = S_SEARCH;
          else if (goodcnt == GOOD_MAX)
            state_nx = S_WAIT_V;
          else
            goodcnt_nx = goodcnt + 8'd1;
        end
      end
      S_WAIT_V: begin
        if (vs_fall)
          state_nx = S_LOCKED;
      end
      default: begin
        if (lose_lock)
          state_nx = S_SEARCH;
      end
    endcase
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state   <= S_SEARCH;
      goodcnt <= 8'd0;
    end else begin
      state   <= state_nx;
      goodcnt <= goodcnt_nx;
    end
  end

  assign locked = (state == S_LOCKED);

  // Window position; upper bits of wx/wy zero means inside the 64-wide span
  assign ax     = hc - H_ACT;
  assign ay     = vc - V_ACT;
  assign wx     = ax - X0;
  assign wy     = ay - Y0;
  assign in_win = (hc >= H_ACT) && (vc >= V_ACT) &&
                  (ax >= X0) && (ay >= Y0) &&
                  (wx[9:6] == 4'd0) && (wy[9:6] == 4'd0);
  assign idx    = {wy[5:3], wx[5:3]};
  assign sample = locked && in_win && (wx[2:0] == 3'd4) && (wy[2:0] == 3'd4);

  // A frame is only published if every cell was seen and lock survives the closing vsync
  assign capture = locked && vs_fall && (&seen) && !lose_lock;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      shadow      <= 64'd0;
      seen        <= 64'd0;
      frame_data  <= 64'd0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= capture;
      if (capture)
        frame_data <= shadow;
      if (vs_fall)
        seen <= 64'd0;
      else if (sample)
        seen[idx] <= 1'b1;
      if (sample)
        shadow[idx] <= (red_r >= THRESH_V);
    end
  end

`ifdef VGA_CAP_ERRCNT_EN
  always_ff @(posedge dclk or posedge clr) begin
    if (clr)
      sync_err <= 8'd0;
    else if (lose_lock && (sync_err != 8'hFF))
      sync_err <= sync_err + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_bitmap_capture.sv
// Directed bench for vga_bitmap_capture using a shrunken sync timing so each frame is a few thousand clocks.
module tb_vga_bitmap_capture;

  localparam int HP    = 72;
  localparam int VL    = 68;
  localparam int HPUL  = 2;
  localparam int HBPV  = 2;
  localparam int VPUL  = 1;
  localparam int VBPV  = 1;
  localparam int PADL  = 2;
  localparam int PADT  = 1;
  localparam int FRAME = HP * VL;

  logic        dclk = 1'b0;
  logic        clr;
  logic        hsync, vsync;
  logic [3:0]  red, green, blue;
  logic        locked;
  logic [63:0] frame_data;
  logic        frame_valid;
`ifdef VGA_CAP_ERRCNT_EN
  logic [7:0]  sync_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  int          gen_h, gen_v;
  logic [63:0] vdata;
  logic        const_mode;
  logic [3:0]  const_red;
  logic        stretch_req;
  bit          got;
  int          n, fv_seen, guard;

  vga_bitmap_capture #(
    .HPIXELS(HP), .VLINES(VL), .HPULSE(HPUL), .HBP(HBPV), .VPULSE(VPUL), .VBP(VBPV),
    .PAD_LEFT(PADL), .PAD_TOP(PADT), .THRESH(8), .LOCK_CNT(4)
  ) dut (
    .dclk        (dclk),
    .clr         (clr),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .locked      (locked),
    .frame_data  (frame_data),
    .frame_valid (frame_valid)
`ifdef VGA_CAP_ERRCNT_EN
    ,
    .sync_err    (sync_err)
`endif
  );

  always #20 dclk = ~dclk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One dclk: advance the reference display generator and drive its outputs
  task automatic tick();
    int px, py;
    logic [5:0] bi;
    @(posedge dclk);
    #1;
    if (stretch_req && gen_v == 30 && gen_h == HP - 1) begin
      stretch_req = 1'b0;
    end else if (gen_h == HP - 1) begin
      gen_h = 0;
      gen_v = (gen_v == VL - 1) ? 0 : gen_v + 1;
    end else begin
      gen_h++;
    end
    hsync = (gen_h < HPUL) ? 1'b0 : 1'b1;
    vsync = (gen_v < VPUL) ? 1'b0 : 1'b1;
    px = gen_h - (HPUL + HBPV + PADL);
    py = gen_v - (VPUL + VBPV + PADT);
    if (px >= 0 && px < 64 && py >= 0 && py < 64) begin
      bi  = 6'((py / 8) * 8 + px / 8);
      red = const_mode ? const_red : (vdata[bi] ? 4'hF : 4'h0);
    end else begin
      red = 4'h0;
    end
    green = red ^ 4'h5;
    blue  = ~red;
  endtask

  task automatic wait_fv(input int max, output bit g, output int cnt);
    g = 1'b0;
    cnt = 0;
    while (!g && cnt < max) begin
      tick();
      cnt++;
      if (frame_valid === 1'b1) g = 1'b1;
    end
  endtask

  task automatic wait_lock(input int max, output bit g, output int cnt);
    g = 1'b0;
    cnt = 0;
    while (!g && cnt < max) begin
      tick();
      cnt++;
      if (locked === 1'b1) g = 1'b1;
    end
  endtask

  task automatic expect_frame(input string tag, input logic [63:0] exp);
    bit g;
    int c;
    wait_fv(FRAME + 20, g, c);
    chk1({tag, "_valid"}, g, 1'b1);
    chk64({tag, "_data"}, frame_data, exp);
  endtask

  initial begin
    clr = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    red = 4'h0;
    green = 4'h0;
    blue = 4'h0;
    gen_h = HP - 1;
    gen_v = VL - 1;
    vdata = 64'hA5A5_0F0F_FF00_1234;
    const_mode = 1'b0;
    const_red = 4'h0;
    stretch_req = 1'b0;

    // Reset state
    repeat (3) tick();
    chk1("rst_locked", locked, 1'b0);
    chk64("rst_frame_data", frame_data, 64'd0);
    chk1("rst_frame_valid", frame_valid, 1'b0);
`ifdef VGA_CAP_ERRCNT_EN
    chk64("rst_sync_err", 64'(sync_err), 64'd0);
`endif
    clr = 1'b0;

    // Loopback: lock within one frame plus a few lines, then one pulse per frame
    wait_lock(FRAME + 6 * HP, got, n);
    chk1("lock_reached", got, 1'b1);
    chk64("no_data_at_lock", frame_data, 64'd0);
    wait_fv(FRAME + 20, got, n);
    chk1("first_fv", got, 1'b1);
    chk64("loop_data", frame_data, 64'hA5A5_0F0F_FF00_1234);
    chk64("fv_after_lock_frame", 64'(n), 64'(FRAME));
    tick();
    chk1("fv_one_cycle", frame_valid, 1'b0);
    wait_fv(FRAME + 20, got, n);
    chk1("second_fv", got, 1'b1);
    chk64("fv_period", 64'(n), 64'(FRAME - 1));
    chk64("loop_data2", frame_data, 64'hA5A5_0F0F_FF00_1234);

    // Single-bit walk: corners and an interior cell
    vdata = 64'd1;
    expect_frame("walk0", 64'd1);
    vdata = 64'd1 << 27;
    expect_frame("walk27", 64'h0000_0000_0800_0000);
    vdata = 64'd1 << 63;
    expect_frame("walk63", 64'h8000_0000_0000_0000);

    // Threshold boundary
    const_mode = 1'b1;
    const_red = 4'd7;
    expect_frame("red7", 64'h0);
    const_red = 4'd8;
    expect_frame("red8", 64'hFFFF_FFFF_FFFF_FFFF);
    const_mode = 1'b0;

    // One line stretched by a clock mid-frame
    vdata = 64'hDEAD_BEEF_0BAD_F00D;
    stretch_req = 1'b1;
    guard = 0;
    while (stretch_req && guard < FRAME) begin
      tick();
      guard++;
    end
    chk1("stretch_happened", stretch_req, 1'b0);
    tick();
    tick();
    chk1("locked_before_bad_edge", locked, 1'b1);
    tick();
    chk1("unlocked_after_bad_edge", locked, 1'b0);
`ifdef VGA_CAP_ERRCNT_EN
    chk64("sync_err_one", 64'(sync_err), 64'd1);
`endif
    fv_seen = 0;
    guard = 0;
    while (!(gen_v == 0 && gen_h == 10) && guard < FRAME) begin
      tick();
      guard++;
      if (frame_valid === 1'b1) fv_seen++;
    end
    chk64("no_fv_glitch_frame", 64'(fv_seen), 64'd0);
    chk64("held_data_glitch", frame_data, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_fv(FRAME + 20, got, n);
    chk1("relock_fv", got, 1'b1);
    chk64("relock_data", frame_data, 64'hDEAD_BEEF_0BAD_F00D);

    // Reset pulse in the middle of the window
    vdata = 64'h0123_4567_89AB_CDEF;
    guard = 0;
    while (!(gen_v == 30 && gen_h == 30) && guard < FRAME) begin
      tick();
      guard++;
    end
    clr = 1'b1;
    tick();
    chk1("clr_locked", locked, 1'b0);
    chk1("clr_fv", frame_valid, 1'b0);
    chk64("clr_data", frame_data, 64'd0);
`ifdef VGA_CAP_ERRCNT_EN
    chk64("clr_sync_err", 64'(sync_err), 64'd0);
`endif
    tick();
    tick();
    clr = 1'b0;
    wait_lock(FRAME, got, n);
    chk1("clr_relock", got, 1'b1);
    chk64("clr_data_at_lock", frame_data, 64'd0);
    wait_fv(FRAME + 20, got, n);
    chk1("clr_fv_after", got, 1'b1);
    chk64("clr_fv_second_vsync", 64'(n), 64'(FRAME));
    chk64("clr_capture_data", frame_data, 64'h0123_4567_89AB_CDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
